// File: rtl/kmap_lut_eval.sv
// kmap_lut_eval
//   A truth-table evaluator that can be loaded at run time. The table has
//   2^N entries, and each entry holds a value bit and a care bit. Care = 0
//   marks a don't-care minterm. While IDLE, the block evaluates one N-bit
//   vector per cycle, and the result is registered one cycle later. On
//   request it enters SCAN and reports every entry in order, one per cycle.
//
// Parameters
//   N        number of function inputs (2..8); table depth is 2^N
//   DC_FILL  value driven on f when the reported entry is don't-care
//
// Ports
//   clk, resetn            clock; synchronous active-low reset
//   wr_en/wr_addr/
//   wr_val/wr_care         table write port, accepted in any state
//   in_valid, x            evaluation request and input vector
//   in_ready               evaluation can be accepted (IDLE, no scan_start)
//   scan_start             begin a full-table scan (honoured in IDLE only)
//   busy                   scan in progress
//   out_valid              one-cycle result strobe, no backpressure
//   f, f_dc                reported function value / don't-care flag
//   out_addr, out_last     index of reported entry / final scan entry
module kmap_lut_eval #(
  parameter int unsigned N       = 4,
  parameter bit          DC_FILL = 1'b0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_en,
  input  logic [N-1:0] wr_addr,
  input  logic         wr_val,
  input  logic         wr_care,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic         scan_start,
  output logic         busy,
  output logic         out_valid,
  output logic         f,
  output logic         f_dc,
  output logic [N-1:0] out_addr,
  output logic         out_last
);

  localparam int unsigned DEPTH = 1 << N;
  // The counter is one bit wider than the index, so its last value never
  // wraps back onto entry 0.
  localparam logic [N:0]  LAST  = {1'b0, {N{1'b1}}};

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0] val_q, care_q;

  logic             scan_last;
  logic             rd_en;
  logic [N-1:0]     rd_addr;
  logic             rd_val, rd_care;

  logic             out_valid_q;
  logic             f_q, f_dc_q, out_last_q;
  logic [N-1:0]     out_addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (scan_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy      = (state_q == SCAN);
    in_ready  = (state_q == IDLE) && !scan_start;
    scan_last = busy && (cnt_q == LAST);
    rd_en     = busy || (in_valid && in_ready);
    rd_addr   = busy ? cnt_q[N-1:0] : x;
  end

  // The read taps the current register contents. A write at the same edge
  // is therefore seen only by later reads (read-before-write).
  assign rd_val  = val_q[rd_addr];
  assign rd_care = care_q[rd_addr];

  // Table storage. Reset returns every entry to don't-care.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      val_q  <= '0;
      care_q <= '0;
    end else if (wr_en) begin
      val_q[wr_addr]  <= wr_val;
      care_q[wr_addr] <= wr_care;
    end
  end

  // Result register. The data fields hold their values when no read occurs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      f_q         <= 1'b0;
      f_dc_q      <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= rd_en;
      if (rd_en) begin
        f_q        <= rd_care ? rd_val : DC_FILL;
        f_dc_q     <= !rd_care;
        out_addr_q <= rd_addr;
        out_last_q <= scan_last;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign f_dc      = f_dc_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_kmap_lut_eval.sv
module tb_kmap_lut_eval;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       wr_val, wr_care;
  logic       in_valid, in_ready;
  logic [3:0] x;
  logic       scan_start, busy;
  logic       out_valid, f, f_dc, out_last;
  logic [3:0] out_addr;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  logic [15:0] mdl_val  = '0;
  logic [15:0] mdl_care = '0;

  typedef struct {
    logic        f;
    logic        dc;
    logic [3:0]  addr;
    logic        last;
    int unsigned cyc;
  } exp_t;

  exp_t sbq[$];

  kmap_lut_eval #(.N(4), .DC_FILL(1'b0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_val    (wr_val),
    .wr_care   (wr_care),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .scan_start(scan_start),
    .busy      (busy),
    .out_valid (out_valid),
    .f         (f),
    .f_dc      (f_dc),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The expectation is taken from the model before the edge, so a write at
  // the same edge does not affect it.
  task automatic push_entry(input int a, input bit last);
    exp_t e;
    e.f    = mdl_care[a] ? mdl_val[a] : 1'b0;
    e.dc   = !mdl_care[a];
    e.addr = a[3:0];
    e.last = last;
    e.cyc  = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic drive(input bit we, input int wa, input bit wv, input bit wc,
                       input bit ev, input int ex);
    wr_en = we; wr_addr = wa[3:0]; wr_val = wv; wr_care = wc;
    in_valid = ev; x = ex[3:0]; scan_start = 1'b0;
    if (ev) push_entry(ex, 1'b0);
    step();
    if (we) begin
      mdl_val[wa]  = wv;
      mdl_care[wa] = wc;
    end
    wr_en = 1'b0; in_valid = 1'b0;
  endtask

  // The scan is entered at edge k, and entry i is reported after edge k+1+i.
  // When abort_at < 16, reset is asserted at the edge that would have
  // reported entry abort_at.
  task automatic run_scan(input int abort_at);
    scan_start = 1'b1; in_valid = 1'b1; x = 4'd3;
    #1;
    chk("in_ready_at_start", in_ready, 0);
    step();
    scan_start = 1'b0; in_valid = 1'b0;
    chk("busy_on_entry", busy, 1);
    chk("out_valid_on_entry", out_valid, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == abort_at) begin
        resetn = 1'b0;
        step();
        chk("busy_after_abort", busy, 0);
        chk("out_valid_after_abort", out_valid, 0);
        resetn   = 1'b1;
        mdl_val  = '0;
        mdl_care = '0;
        return;
      end
      push_entry(i, i == 15);
      if (i == 1 && abort_at == 16) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_val = 1'b1; wr_care = 1'b1;
      end
      if (i == 7) begin
        in_valid = 1'b1; scan_start = 1'b1; x = 4'd0;
      end
      if (i == 5) begin
        #1;
        chk("in_ready_in_scan", in_ready, 0);
      end
      step();
      if (wr_en) begin
        mdl_val[wr_addr]  = wr_val;
        mdl_care[wr_addr] = wr_care;
      end
      wr_en = 1'b0; in_valid = 1'b0; scan_start = 1'b0;
    end
    chk("busy_after_scan", busy, 0);
    chk("in_ready_after_scan", in_ready, 1);
  endtask

  // Scoreboard monitor. It samples the outputs mid-cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("f", f, e.f);
        chk("f_dc", f_dc, e.dc);
        chk("out_addr", out_addr, e.addr);
        chk("out_last", out_last, e.last);
        chk("latency", cyc, e.cyc);
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      chk("missing_out_valid", 0, 1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; x = '0; scan_start = 1'b0;
    // A write issued during reset must be discarded.
    wr_en = 1'b1; wr_addr = 4'd5; wr_val = 1'b1; wr_care = 1'b1;
    repeat (2) step();
    wr_en = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_f", f, 0);
    chk("rst_f_dc", f_dc, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    resetn = 1'b1;

    // After reset the whole table is don't-care.
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, i);

    // Program the table, then evaluate 4, 7 and 5 back-to-back.
    drive(1, 2, 0, 1, 0, 0);
    drive(1, 4, 1, 1, 0, 0);
    drive(1, 6, 1, 1, 0, 0);
    drive(1, 7, 0, 1, 0, 0);
    drive(1, 11, 1, 1, 0, 0);
    drive(1, 12, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 4);
    drive(0, 0, 0, 0, 1, 7);
    drive(0, 0, 0, 0, 1, 5);

    // Write and read the same entry at one edge: the read sees the old contents.
    drive(1, 4, 0, 1, 1, 4);
    drive(0, 0, 0, 0, 1, 4);
    step();

    // Full scan. Entry 3 is written during the 2nd scan cycle.
    run_scan(16);
    drive(0, 0, 0, 0, 1, 3);
    step();

    // Reset aborts a scan in the middle, then the table reads back empty.
    run_scan(9);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1, i);

    repeat (3) step();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kmap_lut_eval.md
# kmap_lut_eval

Parametrised, run-time programmable truth-table evaluator. Each of its 2^N entries holds a value bit and a care bit, so don't-care minterms are explicit. It evaluates N-bit input vectors with a registered single-cycle latency. It can also scan the whole table out sequentially for checking. The block is the generalised, loadable successor of the team's fixed 4-input K-map combinational functions, and sits wherever a small Boolean function must be reconfigured without re-synthesis.

## Interface
Parameters:
- N, 4: number of function inputs. The table depth is 2^N entries. Legal range is 2..8.
- DC_FILL, 0: value driven on f when the addressed entry is don't-care.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock for all state.
- resetn  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- wr_en  input  1  table write strobe.
- wr_addr  input  N  entry index to write.
- wr_val  input  1  value bit to store.
- wr_care  input  1  care bit to store; 0 marks the entry don't-care.
- in_valid  input  1  evaluation request.
- in_ready  output  1  combinational; equals !busy && !scan_start.
- x  input  N  input vector to evaluate.
- scan_start  input  1  request a full-table scan; honoured only in IDLE.
- busy  output  1  high while in SCAN.
- out_valid  output  1  one-cycle result strobe. There is no backpressure.
- f  output  1  function value.
- f_dc  output  1  1 when the reported entry is don't-care.
- out_addr  output  N  index of the reported entry.
- out_last  output  1  high with the final scan entry (index 2^N-1).

## Operation
- Storage: 2^N entries of {val, care}. Reset clears every entry to {0,0}, i.e. all entries don't-care.
- Write: when wr_en is high at an edge, entry[wr_addr] takes {wr_val, wr_care}. Writes are accepted in any state.
- Reporting an entry e (value v, care c):
  - f = c ? v : DC_FILL
  - f_dc = !c
- FSM states: IDLE and SCAN.
- IDLE, scan_start=1: go to SCAN, with scan counter cnt=0. No evaluation is accepted that cycle, because in_ready is 0.
- IDLE, in_valid && in_ready: register the result for entry[x]. Set out_addr=x and out_last=0.
- SCAN, every cycle:
  - Register the result for entry[cnt]; out_addr=cnt.
  - out_last = (cnt == 2^N-1).
  - cnt increments.
  - After reporting entry 2^N-1, return to IDLE.
- SCAN ignores in_valid and scan_start.
- Reads are read-before-write: if a write and a read hit the same entry at the same edge, the read reports the old contents and the write lands.
- cnt is N+1 bits wide, or it compares before incrementing, so it never aliases at 2^N. The scan terminates exactly once.
- Outputs when out_valid=0: f, f_dc, out_addr and out_last hold their last values. They are don't-care to consumers.

## Timing
- Reset values: out_valid=0, f=0, f_dc=0, out_addr=0, out_last=0, busy=0, state=IDLE, cnt=0, whole table {0,0}.
- Reset has priority over all other inputs, including a concurrent write.
- Reset mid-scan aborts the scan. The next cycle shows busy=0 and out_valid=0.
- Evaluation latency: request accepted at edge k gives out_valid=1 with its result after edge k. That is one cycle, so a new result can appear every cycle.
- Write-to-read: a write at edge k is visible to an evaluation accepted at edge k+1 or later.
- Scan with scan_start seen at edge k:
  - busy is high after edge k.
  - Entries 0..2^N-1 appear after edges k+1..k+2^N, one per cycle.
  - out_last is high after edge k+2^N.
  - busy falls after edge k+2^N, and in_ready rises in the same cycle.
- out_valid is 0 after edge k, the cycle in which the scan is entered.

## Test plan
- Reset, then evaluate x=0..15 (N=4, DC_FILL=0) -> every result has f=0, f_dc=1, one cycle after request.
- Program 2->{0,1}, 4->{1,1}, 6->{1,1}, 7->{0,1}, 11->{1,1}, 12->{1,1}; evaluate 4, 7, 5 back-to-back -> f=1,0,0 with f_dc=0,0,1 on three consecutive cycles, out_addr=4,7,5.
- Same-edge write {0,1} to 4 and evaluate x=4 -> f=1 (old value); re-evaluate x=4 next cycle -> f=0.
- scan_start together with in_valid in IDLE -> in_ready=0; 16 consecutive out_valid pulses with out_addr 0..15; out_last only on 15; busy low immediately after.
- Write 3->{1,1} at the 2nd scan cycle; entry 3 is reported later in the same scan with f=1, f_dc=0.
- resetn=0 during scan entry 9 -> next cycle busy=0, out_valid=0, and all entries read back {0,0}.
